// File: rtl/mu_mem_arbiter_if.sv
// Bus bundle for mu_mem_arbiter: IF and D requester handshakes plus the shared memory port.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface mu_mem_arbiter_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  if_req_i;
   logic [DATA_WIDTH-1:0] if_addr_i;
   logic                  if_gnt_o;
   logic                  if_rvalid_o;
   logic [DATA_WIDTH-1:0] if_rdata_o;

   logic                  d_req_i;
   logic                  d_we_i;
   logic [DATA_WIDTH-1:0] d_addr_i;
   logic [DATA_WIDTH-1:0] d_wdata_i;
   logic                  d_gnt_o;
   logic                  d_rvalid_o;
   logic [DATA_WIDTH-1:0] d_rdata_o;
   logic                  d_err_o;

   logic                  mem_we_o;
   logic [DATA_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_wdata_o;
   logic [DATA_WIDTH-1:0] mem_rdata_i;
   logic                  busy_o;

   modport slave (
      input  if_req_i, if_addr_i,
      output if_gnt_o, if_rvalid_o, if_rdata_o,
      input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
      output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
      output mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i,
      output busy_o
   );

   modport master (
      output if_req_i, if_addr_i,
      input  if_gnt_o, if_rvalid_o, if_rdata_o,
      output d_req_i, d_we_i, d_addr_i, d_wdata_i,
      input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
      input  mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i,
      input  busy_o
   );
endinterface

// File: rtl/mu_mem_arbiter.sv
// Round-robin IF/D arbiter for one memory port: IDLE->ACC->RESP, gnt at N+1, rvalid at N+2.
// Backpressure: requesters hold req until gnt; loser keeps req high and is served next; ROM stores error out.
module mu_mem_arbiter #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] ROM_LIMIT  = 32'h1000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   mu_mem_arbiter_if.slave    bus
);

   typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

   localparam logic WIN_IF = 1'b0;
   localparam logic WIN_D  = 1'b1;

   state_t                state_q,     state_d;
   logic                  last_win_q,  last_win_d;
   logic                  win_q,       win_d;
   logic                  we_q,        we_d;
   logic [DATA_WIDTH-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic                  mem_we_q,    mem_we_d;
   logic                  if_gnt_q,    if_gnt_d;
   logic                  d_gnt_q,     d_gnt_d;
   logic                  if_rvalid_q, if_rvalid_d;
   logic                  d_rvalid_q,  d_rvalid_d;
   logic                  d_err_q,     d_err_d;
   logic [DATA_WIDTH-1:0] if_rdata_q,  if_rdata_d;
   logic [DATA_WIDTH-1:0] d_rdata_q,   d_rdata_d;
   logic                  busy_q,      busy_d;

   logic                  pick;
   logic [DATA_WIDTH-1:0] pick_addr;
   logic                  pick_we;

   always_comb begin
      state_d     = state_q;
      last_win_d  = last_win_q;
      win_d       = win_q;
      we_d        = we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      if_gnt_d    = 1'b0;
      d_gnt_d     = 1'b0;
      if_rvalid_d = 1'b0;
      d_rvalid_d  = 1'b0;
      d_err_d     = 1'b0;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      busy_d      = busy_q;

      // Under contention the side that did not win last time goes first.
      if (bus.if_req_i && bus.d_req_i) begin
         pick = (last_win_q == WIN_D) ? WIN_IF : WIN_D;
      end else begin
         pick = bus.d_req_i ? WIN_D : WIN_IF;
      end
      pick_addr = (pick == WIN_D) ? bus.d_addr_i : bus.if_addr_i;
      pick_we   = (pick == WIN_D) ? bus.d_we_i : 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.if_req_i || bus.d_req_i) begin
               if (bus.if_req_i && bus.d_req_i) begin
                  last_win_d = pick;
               end
               win_d       = pick;
               we_d        = pick_we;
               mem_addr_d  = pick_addr;
               mem_wdata_d = (pick == WIN_D) ? bus.d_wdata_i : '0;
               mem_we_d    = pick_we && (pick_addr >= ROM_LIMIT);
               if_gnt_d    = (pick == WIN_IF);
               d_gnt_d     = (pick == WIN_D);
               busy_d      = 1'b1;
               state_d     = ACC;
            end
         end
         ACC: begin
            // Read data is sampled before the RAM commits, so stores see the old word.
            if (win_q == WIN_D) begin
               d_rdata_d  = bus.mem_rdata_i;
               d_rvalid_d = 1'b1;
               d_err_d    = we_q && (mem_addr_q < ROM_LIMIT);
            end else begin
               if_rdata_d  = bus.mem_rdata_i;
               if_rvalid_d = 1'b1;
            end
            state_d = RESP;
         end
         RESP: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_win_q  <= WIN_D;
         win_q       <= WIN_IF;
         we_q        <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         if_gnt_q    <= 1'b0;
         d_gnt_q     <= 1'b0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         d_err_q     <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_win_q  <= last_win_d;
         win_q       <= win_d;
         we_q        <= we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         if_gnt_q    <= if_gnt_d;
         d_gnt_q     <= d_gnt_d;
         if_rvalid_q <= if_rvalid_d;
         d_rvalid_q  <= d_rvalid_d;
         d_err_q     <= d_err_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.if_gnt_o    = if_gnt_q;
   assign bus.if_rvalid_o = if_rvalid_q;
   assign bus.if_rdata_o  = if_rdata_q;
   assign bus.d_gnt_o     = d_gnt_q;
   assign bus.d_rvalid_o  = d_rvalid_q;
   assign bus.d_rdata_o   = d_rdata_q;
   assign bus.d_err_o     = d_err_q;
   assign bus.mem_we_o    = mem_we_q;
   assign bus.mem_addr_o  = mem_addr_q;
   assign bus.mem_wdata_o = mem_wdata_q;
   assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_mu_mem_arbiter.sv
// Directed bench for mu_mem_arbiter with a small ROM/RAM model on the memory port.
module tb_mu_mem_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   logic ram_clr;
   int   errors = 0;
   int   checks = 0;

   logic [31:0] ram [0:15];
   logic [3:0]  midx;

   mu_mem_arbiter_if #(.DATA_WIDTH(32)) bus ();

   mu_mem_arbiter #(
      .DATA_WIDTH (32),
      .ROM_LIMIT  (32'h1000_0000)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [3:0] idx);
      case (idx)
         4'd1:    rom_word = 32'h2008_0005;
         4'd4:    rom_word = 32'hAC0A_0004;
         default: rom_word = {28'h0BAD_000, idx};
      endcase
   endfunction

   assign midx = bus.mem_addr_o[5:2];
   assign bus.mem_rdata_i = (bus.mem_addr_o < 32'h1000_0000) ? rom_word(midx) : ram[midx];

   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 16; i++) ram[i] <= 32'h0;
      end else if (bus.mem_we_o) begin
         ram[midx] <= bus.mem_wdata_o;
      end
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n         = 1'b0;
      ram_clr       = 1'b1;
      bus.if_req_i  = 1'b0;
      bus.if_addr_i = 32'h0;
      bus.d_req_i   = 1'b0;
      bus.d_we_i    = 1'b0;
      bus.d_addr_i  = 32'h0;
      bus.d_wdata_i = 32'h0;
      tick();
      tick();

      chk1 ("rst_busy",     bus.busy_o,      1'b0);
      chk1 ("rst_if_gnt",   bus.if_gnt_o,    1'b0);
      chk1 ("rst_d_gnt",    bus.d_gnt_o,     1'b0);
      chk1 ("rst_mem_we",   bus.mem_we_o,    1'b0);
      chk1 ("rst_d_err",    bus.d_err_o,     1'b0);
      chk32("rst_mem_addr", bus.mem_addr_o,  32'h0);
      chk32("rst_if_rdata", bus.if_rdata_o,  32'h0);
      chk32("rst_d_rdata",  bus.d_rdata_o,   32'h0);
      rst_n   = 1'b1;
      ram_clr = 1'b0;

      // ROM fetch of word 1
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h0000_0004;
      tick();
      chk1 ("f_if_gnt",   bus.if_gnt_o,   1'b1);
      chk1 ("f_d_gnt",    bus.d_gnt_o,    1'b0);
      chk1 ("f_we_acc",   bus.mem_we_o,   1'b0);
      chk1 ("f_busy_acc", bus.busy_o,     1'b1);
      chk32("f_addr",     bus.mem_addr_o, 32'h0000_0004);
      bus.if_req_i = 1'b0;
      tick();
      chk1 ("f_rvalid",   bus.if_rvalid_o, 1'b1);
      chk32("f_rdata",    bus.if_rdata_o,  32'h2008_0005);
      chk1 ("f_we_resp",  bus.mem_we_o,    1'b0);
      chk1 ("f_gnt_resp", bus.if_gnt_o,    1'b0);
      tick();
      chk1 ("f_rvalid_idle", bus.if_rvalid_o, 1'b0);
      chk1 ("f_busy_idle",   bus.busy_o,      1'b0);

      // RAM store then load back
      bus.d_req_i   = 1'b1;
      bus.d_we_i    = 1'b1;
      bus.d_addr_i  = 32'h1001_0000;
      bus.d_wdata_i = 32'hDEAD_BEEF;
      tick();
      chk1 ("st_d_gnt",  bus.d_gnt_o,     1'b1);
      chk1 ("st_if_gnt", bus.if_gnt_o,    1'b0);
      chk1 ("st_we_acc", bus.mem_we_o,    1'b1);
      chk32("st_wdata",  bus.mem_wdata_o, 32'hDEAD_BEEF);
      bus.d_req_i = 1'b0;
      tick();
      chk1 ("st_rvalid",  bus.d_rvalid_o, 1'b1);
      chk1 ("st_err",     bus.d_err_o,    1'b0);
      chk1 ("st_we_resp", bus.mem_we_o,   1'b0);
      tick();
      bus.d_req_i = 1'b1;
      bus.d_we_i  = 1'b0;
      tick();
      chk1 ("ld_we_acc", bus.mem_we_o, 1'b0);
      bus.d_req_i = 1'b0;
      tick();
      chk1 ("ld_rvalid", bus.d_rvalid_o, 1'b1);
      chk32("ld_rdata",  bus.d_rdata_o,  32'hDEAD_BEEF);
      tick();

      // Store into ROM space is blocked and flagged
      bus.d_req_i   = 1'b1;
      bus.d_we_i    = 1'b1;
      bus.d_addr_i  = 32'h0000_0010;
      bus.d_wdata_i = 32'hCAFE_F00D;
      tick();
      chk1 ("rs_d_gnt",  bus.d_gnt_o,  1'b1);
      chk1 ("rs_we_acc", bus.mem_we_o, 1'b0);
      bus.d_req_i = 1'b0;
      tick();
      chk1 ("rs_err",     bus.d_err_o,    1'b1);
      chk1 ("rs_rvalid",  bus.d_rvalid_o, 1'b1);
      chk1 ("rs_we_resp", bus.mem_we_o,   1'b0);
      chk32("rs_rdata",   bus.d_rdata_o,  32'hAC0A_0004);
      tick();
      chk1 ("rs_err_idle", bus.d_err_o, 1'b0);
      bus.d_we_i    = 1'b0;
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h0000_0010;
      tick();
      bus.if_req_i = 1'b0;
      tick();
      chk32("rs_rom_keep", bus.if_rdata_o, 32'hAC0A_0004);
      tick();

      // Continuous contention from reset
      rst_n = 1'b0;
      tick();
      rst_n         = 1'b1;
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h0000_0004;
      bus.d_req_i   = 1'b1;
      bus.d_we_i    = 1'b0;
      bus.d_addr_i  = 32'h1001_0000;
      for (int t = 0; t < 4; t++) begin
         tick();
         chk1 ($sformatf("rr%0d_if_gnt", t), bus.if_gnt_o, (t % 2) == 0);
         chk1 ($sformatf("rr%0d_d_gnt",  t), bus.d_gnt_o,  (t % 2) == 1);
         chk1 ($sformatf("rr%0d_busy_acc", t), bus.busy_o, 1'b1);
         tick();
         chk1 ($sformatf("rr%0d_busy_resp", t), bus.busy_o, 1'b1);
         chk1 ($sformatf("rr%0d_if_rv", t), bus.if_rvalid_o, (t % 2) == 0);
         chk1 ($sformatf("rr%0d_d_rv",  t), bus.d_rvalid_o,  (t % 2) == 1);
         tick();
         chk1 ($sformatf("rr%0d_busy_idle", t), bus.busy_o, 1'b0);
         chk1 ($sformatf("rr%0d_gnt_idle",  t), bus.if_gnt_o | bus.d_gnt_o, 1'b0);
      end
      bus.if_req_i = 1'b0;
      bus.d_req_i  = 1'b0;
      chk32("rr_d_rdata", bus.d_rdata_o, 32'hDEAD_BEEF);
      tick();

      // Reset during ACC of a RAM store aborts the write
      bus.d_req_i   = 1'b1;
      bus.d_we_i    = 1'b1;
      bus.d_addr_i  = 32'h1001_0004;
      bus.d_wdata_i = 32'h55AA_55AA;
      tick();
      chk1("ab_we_acc", bus.mem_we_o, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk1 ("ab_we_async",   bus.mem_we_o,   1'b0);
      chk1 ("ab_gnt_async",  bus.d_gnt_o,    1'b0);
      chk1 ("ab_busy_async", bus.busy_o,     1'b0);
      chk32("ab_addr_async", bus.mem_addr_o, 32'h0);
      bus.d_req_i = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk1("ab_no_rvalid", bus.d_rvalid_o, 1'b0);
      bus.d_req_i = 1'b1;
      bus.d_we_i  = 1'b0;
      tick();
      bus.d_req_i = 1'b0;
      tick();
      chk1 ("ab_ld_rvalid", bus.d_rvalid_o, 1'b1);
      chk32("ab_ld_rdata",  bus.d_rdata_o,  32'h0);
      tick();

      // IF request held through RESP becomes a second request
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h0000_0004;
      tick();
      chk1("hr_gnt1", bus.if_gnt_o, 1'b1);
      tick();
      chk1("hr_gnt_resp", bus.if_gnt_o, 1'b0);
      tick();
      chk1("hr_gnt_idle", bus.if_gnt_o, 1'b0);
      tick();
      chk1("hr_gnt2", bus.if_gnt_o, 1'b1);
      bus.if_req_i = 1'b0;
      tick();
      chk1("hr_rvalid2", bus.if_rvalid_o, 1'b1);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
